// File: rtl/glitch_filter_if.sv
// Signal bundle between the raw-level source and the glitch filter:
// the raw level and enable in, the filtered level, edge strobes and busy out.
interface glitch_filter_if;
    logic a;
    logic en;
    logic y;
    logic rise;
    logic fall;
    logic busy;

    modport master (
        output a,
        output en,
        input  y,
        input  rise,
        input  fall,
        input  busy
    );

    modport slave (
        input  a,
        input  en,
        output y,
        output rise,
        output fall,
        output busy
    );
endinterface

// File: rtl/glitch_filter.sv
// Synchronising deglitch stage: brings a raw level into clk through a flop chain,
// then only lets y follow once the level has differed for FILTER_CYCLES edges.
module glitch_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    glitch_filter_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [CNT_W-1:0]       cnt_next;
    logic                   y_reg;
    logic                   y_next;
    logic                   rise_reg;
    logic                   rise_next;
    logic                   fall_reg;
    logic                   fall_next;
    logic                   busy_out;
    logic                   s;

    assign s = sync_reg[SYNC_STAGES-1];

    // Synchroniser chain: sync_reg[0] samples the raw level, s is the last flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else if (SYNC_STAGES > 1) begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.a};
        end else begin
            sync_reg <= {SYNC_STAGES{bus.a}};
        end
    end

    // State register: qualification counter, filtered level and strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            y_reg    <= 1'b0;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            y_reg    <= y_next;
            rise_reg <= rise_next;
            fall_reg <= fall_next;
        end
    end

    // Next state: cnt == 0 is STABLE, anything else is QUAL. The terminal
    // compare caps the counter so it never wraps.
    always_comb begin
        cnt_next = cnt_reg;
        y_next   = y_reg;
        if (!bus.en) begin
            y_next   = s;
            cnt_next = '0;
        end else if (s == y_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == CNT_TERM) begin
            y_next   = s;
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
        rise_next = y_next & ~y_reg;
        fall_next = ~y_next & y_reg;
    end

    // Outputs: busy depends on the counter alone.
    always_comb begin
        busy_out = (cnt_reg != '0);
    end

    assign bus.y    = y_reg;
    assign bus.rise = rise_reg;
    assign bus.fall = fall_reg;
    assign bus.busy = busy_out;

endmodule

// File: tb/tb_glitch_filter.sv
// Bench for glitch_filter: two configurations (defaults, and 3-stage sync with
// single-cycle filter) driven together and checked every cycle against a history model.
module tb_glitch_filter;

    localparam int S0   = 2;
    localparam int F0   = 4;
    localparam int S1   = 3;
    localparam int F1   = 1;
    localparam int HMAX = 8192;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    glitch_filter_if bus0 ();
    glitch_filter_if bus1 ();

    glitch_filter #(.SYNC_STAGES(S0), .FILTER_CYCLES(F0), .CNT_W(3)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    glitch_filter #(.SYNC_STAGES(S1), .FILTER_CYCLES(F1), .CNT_W(3)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: full history of sampled a levels since reset; s at an edge is the
    // sample taken SYNC_STAGES edges earlier; y flips after FILTER_CYCLES
    // consecutive enabled edges on which s differs from y.
    bit ahist [2][HMAX];
    int ecnt  [2];
    int run   [2];
    bit my    [2];
    bit mr    [2];
    bit mf    [2];

    function automatic void model_reset(int i);
        ecnt[i] = 0;
        run[i]  = 0;
        my[i]   = 1'b0;
        mr[i]   = 1'b0;
        mf[i]   = 1'b0;
    endfunction

    function automatic void model_edge(int i, bit a, bit en, int ns, int nf);
        bit s;
        bit yn;
        s = (ecnt[i] >= ns) ? ahist[i][(ecnt[i] - ns) % HMAX] : 1'b0;
        ahist[i][ecnt[i] % HMAX] = a;
        ecnt[i]++;
        yn = my[i];
        if (!en) begin
            yn     = s;
            run[i] = 0;
        end else if (s == my[i]) begin
            run[i] = 0;
        end else begin
            run[i]++;
            if (run[i] >= nf) begin
                yn     = s;
                run[i] = 0;
            end
        end
        mr[i] = yn & ~my[i];
        mf[i] = ~yn & my[i];
        my[i] = yn;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_cycle();
        chk("y0",    bus0.y,    my[0]);
        chk("rise0", bus0.rise, mr[0]);
        chk("fall0", bus0.fall, mf[0]);
        chk("busy0", bus0.busy, run[0] != 0);
        chk("y1",    bus1.y,    my[1]);
        chk("rise1", bus1.rise, mr[1]);
        chk("fall1", bus1.fall, mf[1]);
        chk("busy1", bus1.busy, run[1] != 0);
    endtask

    // One clock: drive after the falling edge, model at the rising edge, check at the next falling edge.
    task automatic step(input bit a, input bit en);
        bus0.a  = a;
        bus0.en = en;
        bus1.a  = a;
        bus1.en = en;
        if (!rst_n) begin
            model_reset(0);
            model_reset(1);
        end
        @(posedge clk);
        if (rst_n) begin
            model_edge(0, a, en, S0, F0);
            model_edge(1, a, en, S1, F1);
        end
        @(negedge clk);
        check_cycle();
    endtask

    initial begin
        bit lvl;
        bit ren;
        int len;

        // Reset held with a toggling: everything stays low.
        rst_n = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(k[0], 1'b1);
            chk("rst_y0", bus0.y, 1'b0);
            chk("rst_busy0", bus0.busy, 1'b0);
        end
        $display("phase reset-hold done, cmp=%0d err=%0d", n_cmp, n_err);

        // Release and hold a = 1: default rises at edge 6, 3-stage/1-cycle at edge 4.
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b1);
            if (k == 2) chk("lit_busy_e2", bus0.busy, 1'b0);
            if (k == 3) chk("lit_busy_e3", bus0.busy, 1'b1);
            if (k == 3) chk("lit_y1_e3", bus1.y, 1'b0);
            if (k == 4) chk("lit_y1_e4", bus1.y, 1'b1);
            if (k == 4) chk("lit_rise1_e4", bus1.rise, 1'b1);
            if (k == 5) chk("lit_y_e5", bus0.y, 1'b0);
            if (k == 5) chk("lit_busy_e5", bus0.busy, 1'b1);
            if (k == 6) chk("lit_y_e6", bus0.y, 1'b1);
            if (k == 6) chk("lit_rise_e6", bus0.rise, 1'b1);
            if (k == 6) chk("lit_busy_e6", bus0.busy, 1'b0);
            if (k == 7) chk("lit_rise_e7", bus0.rise, 1'b0);
        end
        $display("phase release-rise done, cmp=%0d err=%0d", n_cmp, n_err);

        // Falling level: fall strobe at edge 6.
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 1'b1);
            if (k == 5) chk("lit_fall_y_e5", bus0.y, 1'b1);
            if (k == 6) chk("lit_fall_e6", bus0.fall, 1'b1);
            if (k == 6) chk("lit_fall_y_e6", bus0.y, 1'b0);
        end
        $display("phase fall done, cmp=%0d err=%0d", n_cmp, n_err);

        // 3-cycle pulse is rejected, 4-cycle pulse passes.
        for (int k = 1; k <= 11; k++) begin
            step(k <= 3, 1'b1);
            chk("glitch3_y0", bus0.y, 1'b0);
        end
        for (int k = 1; k <= 14; k++) begin
            step(k <= 4, 1'b1);
            if (k == 5) chk("pulse4_y0_e5", bus0.y, 1'b0);
            if (k == 6) chk("pulse4_y0_e6", bus0.y, 1'b1);
        end
        $display("phase glitch done, cmp=%0d err=%0d", n_cmp, n_err);

        // Interrupted qualification: 1,1,0 then 1 x8.
        for (int k = 1; k <= 23; k++) begin
            step((k != 3) && (k <= 11), 1'b1);
            if (k == 8) chk("interrupt_y0_e8", bus0.y, 1'b0);
            if (k == 9) chk("interrupt_y0_e9", bus0.y, 1'b1);
        end
        $display("phase interrupt done, cmp=%0d err=%0d", n_cmp, n_err);

        // Bypass, a toggling every 2 cycles starting high.
        for (int k = 1; k <= 20; k++) begin
            step(((k - 1) / 2) % 2 == 0 && k <= 16, 1'b0);
            if (k == 2) chk("bypass_y0_e2", bus0.y, 1'b0);
            if (k == 3) chk("bypass_y0_e3", bus0.y, 1'b1);
            if (k == 3) chk("bypass_rise0_e3", bus0.rise, 1'b1);
        end
        $display("phase bypass done, cmp=%0d err=%0d", n_cmp, n_err);

        // Drop en while the count is 2.
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) step(1'b1, 1'b1);
        chk("en_drop_busy_before", bus0.busy, 1'b1);
        step(1'b1, 1'b0);
        chk("en_drop_y0", bus0.y, 1'b1);
        chk("en_drop_busy0", bus0.busy, 1'b0);
        chk("en_drop_rise0", bus0.rise, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1);
        $display("phase en-drop done, cmp=%0d err=%0d", n_cmp, n_err);

        // Randomised runs, occasional mid-stream reset.
        for (int r = 0; r < 400; r++) begin
            lvl = 1'($urandom_range(0, 1));
            ren = ($urandom_range(0, 9) != 0);
            len = $urandom_range(1, 7);
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                step(lvl, ren);
                step(lvl, ren);
                rst_n = 1'b1;
            end
            for (int k = 0; k < len; k++) step(lvl, ren);
        end
        $display("phase random done, cmp=%0d err=%0d", n_cmp, n_err);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
